multi_cycle_control: RTL

- Main control FSM for the multi-cycle MIPS datapath. It decodes the 6-bit opcode and sequences the datapath through fetch, decode, execute, memory and write-back steps.
- It is the initiator side of the ALUOp interface: it drives alu_op[1:0] to alu_control, which returns the 4-bit ALU operation.
- It stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multi_cycle_control.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back, drives alu_op to alu_control and counts retired instructions.
module multi_cycle_control #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'h0,
        S_DECODE     = 4'h1,
        S_MEM_ADDR   = 4'h2,
        S_MEM_READ   = 4'h3,
        S_MEM_WB     = 4'h4,
        S_MEM_WRITE  = 4'h5,
        S_EXECUTE    = 4'h6,
        S_R_COMPLETE = 4'h7,
        S_BRANCH     = 4'h8,
        S_JUMP       = 4'h9,
        S_IDLE       = 4'hF
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       fetch;
    } ctrl_t;

    // Control word for a state; registered against the next state so outputs come from flops.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:    c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_COMPLETE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t cur, nxt;
    ctrl_t  ctrl;
    logic   retire;
    logic   legal_op;

    assign legal_op = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                      (opcode == OP_BEQ) || (opcode == OP_J);

    always_comb begin
        nxt    = S_FETCH;
        retire = 1'b0;
        case (cur)
            S_IDLE:       nxt = S_FETCH;
            S_FETCH:      nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) nxt = S_MEM_ADDR;
                else if (opcode == OP_RTYPE)            nxt = S_EXECUTE;
                else if (opcode == OP_BEQ)              nxt = S_BRANCH;
                else if (opcode == OP_J)                nxt = S_JUMP;
                else                                    nxt = S_FETCH;
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      nxt = S_MEM_READ;
                else if (opcode == OP_SW) nxt = S_MEM_WRITE;
                else                      nxt = S_FETCH;
            end
            S_MEM_READ:   nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_MEM_WRITE: begin
                nxt    = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire = mem_ready;
            end
            S_EXECUTE:    nxt = S_R_COMPLETE;
            S_R_COMPLETE, S_BRANCH, S_JUMP: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default:      nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur           <= S_IDLE;
            ctrl          <= '0;
            instr_retired <= '0;
        end else begin
            cur  <= nxt;
            ctrl <= decode_ctrl(nxt);
            if (retire) instr_retired <= instr_retired + COUNT_W'(1);
        end
    end

    // FETCH only commits PC and IR once memory has returned the instruction.
    assign pc_write      = ctrl.pc_write | (ctrl.fetch & mem_ready);
    assign ir_write      = ctrl.fetch & mem_ready;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign state         = cur;
    assign illegal_op    = (cur == S_DECODE) && !legal_op;

endmodule
